// File: rtl/game_types.sv
// Shared types for the game FSM and the guess scorer.
package game_types;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GUESS_D3,
        S_GUESS_D2,
        S_GUESS_D1,
        S_GUESS_D0,
        S_SHOW_RESULT,
        S_WIN,
        S_LOSE
    } state_t;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_SCAN,
        SC_WRITE
    } scan_state_t;

    typedef struct packed {
        logic [3:0][3:0] digits;
        logic [2:0]      a;
        logic [2:0]      b;
    } hist_entry_t;

    localparam int HIST_DEPTH_DEFAULT = 5;

endpackage

// File: rtl/digit_match.sv
// Compares one guess digit against the whole target vector.
module digit_match
    import game_types::*;
#(
    parameter int DIGITS = 4,
    parameter int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic [3:0]              g_digit,
    input  logic [DIGITS-1:0][3:0]  t_vec,
    input  logic [IW-1:0]           pos,
    output logic                    hit_a,
    output logic                    hit_b
);

    always_comb begin
        hit_a = (t_vec[pos] == g_digit);
        hit_b = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if ((IW'(j) != pos) && (t_vec[j] == g_digit)) begin
                hit_b = 1'b1;
            end
        end
    end

endmodule

// File: rtl/guess_scorer.sv
// Scores each committed guess serially and keeps a browsable
// circular history of scored guesses.
module guess_scorer
    import game_types::*;
#(
    parameter int HIST_DEPTH = HIST_DEPTH_DEFAULT,
    parameter int DIGITS     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  state_t     current_state,
    input  logic [3:0] target [DIGITS],
    input  logic [3:0] guess [DIGITS],
    input  logic       browse_older,
    input  logic       browse_newer,
    output logic       busy,
    output logic       score_valid,
    output logic [2:0] a_count,
    output logic [2:0] b_count,
    output logic [2:0] hist_count,
    output logic [2:0] view_idx,
    output logic [3:0] view_guess [DIGITS],
    output logic [2:0] view_a,
    output logic [2:0] view_b
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    scan_state_t            sc_state, sc_next;
    state_t                 prev_state;
    logic [DIGITS-1:0][3:0] g_snap, t_snap;
    logic [IW-1:0]          idx;
    logic [2:0]             acc_a, acc_b;
    logic [2:0]             acc_a_nxt, acc_b_nxt;
    logic                   hit_a, hit_b;
    logic                   trigger, clear, write_en;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            rd_sum;
    logic [2:0]             view_max;
    hist_entry_t            hist [HIST_DEPTH];
    hist_entry_t            ve;

    assign clear   = (current_state == S_IDLE);
    assign trigger = (prev_state == S_GUESS_D0) &&
                     ((current_state == S_SHOW_RESULT) ||
                      (current_state == S_WIN) ||
                      (current_state == S_LOSE));

    digit_match #(.DIGITS(DIGITS), .IW(IW)) u_match (
        .g_digit (g_snap[idx]),
        .t_vec   (t_snap),
        .pos     (idx),
        .hit_a   (hit_a),
        .hit_b   (hit_b)
    );

    assign acc_a_nxt = acc_a + {2'b00, hit_a};
    assign acc_b_nxt = acc_b + {2'b00, hit_b};

    always_comb begin
        sc_next  = sc_state;
        write_en = 1'b0;
        unique case (sc_state)
            SC_IDLE:  if (trigger) sc_next = SC_SCAN;
            SC_SCAN: begin
                if (idx == '0) begin
                    sc_next  = SC_WRITE;
                    write_en = !clear;
                end
            end
            SC_WRITE: sc_next = SC_IDLE;
            default:  sc_next = SC_IDLE;
        endcase
        if (clear) sc_next = SC_IDLE;
    end

    assign busy     = (sc_state != SC_IDLE);
    assign view_max = (hist_count == 3'd0) ? 3'd0 : hist_count - 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc_state    <= SC_IDLE;
            prev_state  <= S_IDLE;
            g_snap      <= '0;
            t_snap      <= '0;
            idx         <= '0;
            acc_a       <= '0;
            acc_b       <= '0;
            score_valid <= 1'b0;
            a_count     <= '0;
            b_count     <= '0;
            hist_count  <= '0;
            view_idx    <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
        end else begin
            sc_state    <= sc_next;
            prev_state  <= current_state;
            score_valid <= write_en;
            if (clear) begin
                hist_count <= '0;
                wr_ptr     <= '0;
                view_idx   <= '0;
                a_count    <= '0;
                b_count    <= '0;
            end else begin
                if (sc_state == SC_IDLE && trigger) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        g_snap[i] <= guess[i];
                        t_snap[i] <= target[i];
                    end
                    acc_a <= '0;
                    acc_b <= '0;
                    idx   <= IW'(DIGITS - 1);
                end
                if (sc_state == SC_SCAN) begin
                    acc_a <= acc_a_nxt;
                    acc_b <= acc_b_nxt;
                    idx   <= idx - 1'b1;
                end
                if (write_en) begin
                    a_count      <= acc_a_nxt;
                    b_count      <= acc_b_nxt;
                    hist[wr_ptr] <= '{digits: g_snap,
                                      a: acc_a_nxt,
                                      b: acc_b_nxt};
                    wr_ptr <= (wr_ptr == PW'(HIST_DEPTH - 1)) ?
                              '0 : wr_ptr + 1'b1;
                    if (hist_count < 3'(HIST_DEPTH))
                        hist_count <= hist_count + 3'd1;
                end
                // A fresh score always snaps the view back to newest.
                if (write_en || sc_state == SC_WRITE) begin
                    view_idx <= '0;
                end else if (browse_older && !browse_newer) begin
                    if (view_idx < view_max) view_idx <= view_idx + 3'd1;
                end else if (browse_newer && !browse_older) begin
                    if (view_idx != 3'd0) view_idx <= view_idx - 3'd1;
                end
            end
        end
    end

    always_comb begin
        rd_sum = (PW+1)'(wr_ptr) + (PW+1)'(HIST_DEPTH - 1)
               - (PW+1)'(view_idx);
        if (rd_sum >= (PW+1)'(HIST_DEPTH))
            rd_ptr = PW'(rd_sum - (PW+1)'(HIST_DEPTH));
        else
            rd_ptr = PW'(rd_sum);
        ve = hist[rd_ptr];
        if (hist_count == 3'd0) ve = '0;
        for (int i = 0; i < DIGITS; i++) view_guess[i] = ve.digits[i];
        view_a = ve.a;
        view_b = ve.b;
    end

endmodule

// File: tb/tb_guess_scorer.sv
// Directed self-checking bench for guess_scorer.
module tb_guess_scorer;
    import game_types::*;

    logic       clk = 1'b0;
    logic       reset;
    state_t     current_state;
    logic [3:0] target [4];
    logic [3:0] guess [4];
    logic       browse_older, browse_newer;
    logic       busy, score_valid;
    logic [2:0] a_count, b_count, hist_count, view_idx;
    logic [3:0] view_guess [4];
    logic [2:0] view_a, view_b;

    int n_cmp = 0;
    int n_err = 0;

    guess_scorer #(.HIST_DEPTH(5), .DIGITS(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .current_state (current_state),
        .target        (target),
        .guess         (guess),
        .browse_older  (browse_older),
        .browse_newer  (browse_newer),
        .busy          (busy),
        .score_valid   (score_valid),
        .a_count       (a_count),
        .b_count       (b_count),
        .hist_count    (hist_count),
        .view_idx      (view_idx),
        .view_guess    (view_guess),
        .view_a        (view_a),
        .view_b        (view_b)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] vg();
        return {view_guess[3], view_guess[2], view_guess[1], view_guess[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_commit(input logic [15:0] g, input logic [15:0] t,
                                input state_t st);
        current_state = S_GUESS_D0;
        for (int i = 0; i < 4; i++) begin
            guess[i]  = g[4*i +: 4];
            target[i] = t[4*i +: 4];
        end
        step();
        current_state = st;
    endtask

    task automatic run_commit(input logic [15:0] g, input logic [15:0] t);
        start_commit(g, t, S_SHOW_RESULT);
        repeat (6) step();
    endtask

    task automatic go_idle();
        current_state = S_IDLE;
        step();
        current_state = S_GUESS_D3;
        step();
    endtask

    task automatic pulse_older();
        browse_older = 1'b1;
        step();
        browse_older = 1'b0;
    endtask

    task automatic pulse_newer();
        browse_newer = 1'b1;
        step();
        browse_newer = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy, score_valid, a_count, b_count, hist_count, view_idx}
            !== 14'd0) begin
            n_err++;
            $display("FAIL reset_outs: got %b want 0",
                     {busy, score_valid, a_count, b_count, hist_count, view_idx});
        end
        n_cmp++;
        if ({vg(), view_a, view_b} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_view: got %h want 0", {vg(), view_a, view_b});
        end
    endtask

    task automatic test_basic();
        start_commit(16'h3421, 16'h4321, S_SHOW_RESULT);
        for (int k = 1; k <= 6; k++) begin
            step();
            n_cmp++;
            if (score_valid !== (k == 5)) begin
                n_err++;
                $display("FAIL latency k=%0d: got %b want %b",
                         k, score_valid, (k == 5));
            end
            if (k == 5) begin
                n_cmp++;
                if ({a_count, b_count, hist_count} !== {3'd2, 3'd2, 3'd1}) begin
                    n_err++;
                    $display("FAIL basic_ab: got a=%0d b=%0d h=%0d want 2 2 1",
                             a_count, b_count, hist_count);
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_win();
        start_commit(16'h8765, 16'h8765, S_WIN);
        repeat (6) step();
        n_cmp++;
        if ({a_count, b_count} !== {3'd4, 3'd0}) begin
            n_err++;
            $display("FAIL win_ab: got a=%0d b=%0d want 4 0", a_count, b_count);
        end
        n_cmp++;
        if ({vg(), view_a, view_b} !== {16'h8765, 3'd4, 3'd0}) begin
            n_err++;
            $display("FAIL win_view: got %h a=%0d b=%0d want 8765 4 0",
                     vg(), view_a, view_b);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] gv [6];
        gv[0] = 16'h4321; gv[1] = 16'h4312; gv[2] = 16'h1234;
        gv[3] = 16'h7651; gv[4] = 16'h8765; gv[5] = 16'h0219;
        go_idle();
        for (int k = 0; k < 6; k++) run_commit(gv[k], 16'h4321);
        n_cmp++;
        if ({hist_count, a_count, b_count} !== {3'd5, 3'd0, 3'd2}) begin
            n_err++;
            $display("FAIL wrap_count: got h=%0d a=%0d b=%0d want 5 0 2",
                     hist_count, a_count, b_count);
        end
        n_cmp++;
        if (vg() !== 16'h0219) begin
            n_err++;
            $display("FAIL wrap_newest: got %h want 0219", vg());
        end
        repeat (3) pulse_older();
        n_cmp++;
        if ({view_idx, vg(), view_a, view_b} !== {3'd3, 16'h1234, 3'd0, 3'd4}) begin
            n_err++;
            $display("FAIL wrap_idx3: got i=%0d %h a=%0d b=%0d want 3 1234 0 4",
                     view_idx, vg(), view_a, view_b);
        end
        repeat (2) pulse_older();
        n_cmp++;
        if ({view_idx, vg(), view_a, view_b} !== {3'd4, 16'h4312, 3'd2, 3'd2}) begin
            n_err++;
            $display("FAIL wrap_oldest: got i=%0d %h a=%0d b=%0d want 4 4312 2 2",
                     view_idx, vg(), view_a, view_b);
        end
    endtask

    task automatic test_browse();
        go_idle();
        run_commit(16'h4321, 16'h4321);
        run_commit(16'h4312, 16'h4321);
        run_commit(16'h1234, 16'h4321);
        repeat (4) pulse_older();
        n_cmp++;
        if ({view_idx, vg()} !== {3'd2, 16'h4321}) begin
            n_err++;
            $display("FAIL browse_sat_old: got i=%0d %h want 2 4321",
                     view_idx, vg());
        end
        browse_older = 1'b1;
        browse_newer = 1'b1;
        step();
        browse_older = 1'b0;
        browse_newer = 1'b0;
        n_cmp++;
        if (view_idx !== 3'd2) begin
            n_err++;
            $display("FAIL browse_both: got %0d want 2", view_idx);
        end
        repeat (3) pulse_newer();
        n_cmp++;
        if (view_idx !== 3'd0) begin
            n_err++;
            $display("FAIL browse_sat_new: got %0d want 0", view_idx);
        end
        pulse_older();
        start_commit(16'h7651, 16'h4321, S_LOSE);
        repeat (5) step();
        n_cmp++;
        if (score_valid !== 1'b1) begin
            n_err++;
            $display("FAIL browse_wr_valid: got %b want 1", score_valid);
        end
        pulse_older();
        n_cmp++;
        if (view_idx !== 3'd0) begin
            n_err++;
            $display("FAIL browse_wr_prio: got %0d want 0", view_idx);
        end
    endtask

    task automatic test_abort();
        logic seen;
        go_idle();
        seen = 1'b0;
        start_commit(16'h3421, 16'h4321, S_SHOW_RESULT);
        step();
        step();
        current_state = S_IDLE;
        for (int k = 0; k < 6; k++) begin
            step();
            if (score_valid) seen = 1'b1;
        end
        n_cmp++;
        if ({seen, busy, hist_count} !== 5'd0) begin
            n_err++;
            $display("FAIL abort: got sv=%b busy=%b h=%0d want 0 0 0",
                     seen, busy, hist_count);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        current_state = S_GUESS_D3;
        step();
        run_commit(16'h8765, 16'h8765);
        start_commit(16'h3421, 16'h4321, S_SHOW_RESULT);
        repeat (3) step();
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, score_valid, a_count, b_count, hist_count, view_idx,
             vg(), view_a, view_b} !== 36'd0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b a=%0d h=%0d view=%h want all 0",
                     busy, a_count, hist_count, vg());
        end
        step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (score_valid) seen = 1'b1;
        end
        n_cmp++;
        if ({seen, hist_count, a_count} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_nowrite: got sv=%b h=%0d a=%0d want 0 0 0",
                     seen, hist_count, a_count);
        end
    endtask

    initial begin
        reset         = 1'b1;
        current_state = S_IDLE;
        browse_older  = 1'b0;
        browse_newer  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            guess[i]  = '0;
            target[i] = '0;
        end
        step();
        test_reset();
        step();
        reset = 1'b0;
        current_state = S_GUESS_D3;
        step();
        test_basic();
        test_win();
        test_wrap();
        test_browse();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
